// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute stage: op codes, FSM state encoding
// and default datapath widths.
package alu_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_SHW   = 5;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_XOR  = 4'd3;
   localparam logic [3:0] OP_OR   = 4'd4;
   localparam logic [3:0] OP_SLL  = 4'd5;
   localparam logic [3:0] OP_SRL  = 4'd6;
   localparam logic [3:0] OP_SLT  = 4'd7;
   localparam logic [3:0] OP_SLTU = 4'd8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   function automatic logic is_shift(input logic [3:0] op);
      return (op == OP_SLL) || (op == OP_SRL);
   endfunction

endpackage

// File: rtl/alu_comb.sv
// Single-cycle ALU ops and illegal-op detection. Shift ops return A unchanged,
// which is the shift-by-zero result; non-zero shifts are done iteratively upstream.
module alu_comb
   import alu_pkg::*;
#(
   parameter int W = DEF_WIDTH
) (
   input  logic [3:0]   op_i,
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic [W-1:0] result_o,
   output logic         illegal_o
);

   always_comb begin
      result_o  = '0;
      illegal_o = 1'b0;
      case (op_i)
         OP_ADD:         result_o = a_i + b_i;
         OP_SUB:         result_o = a_i - b_i;
         OP_AND:         result_o = a_i & b_i;
         OP_XOR:         result_o = a_i ^ b_i;
         OP_OR:          result_o = a_i | b_i;
         OP_SLL, OP_SRL: result_o = a_i;
         OP_SLT:         result_o[0] = $signed(a_i) < $signed(b_i);
         OP_SLTU:        result_o[0] = a_i < b_i;
         default:        illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_exec_stage.sv
// Execute stage: accepts one op in IDLE, runs SLL/SRL one bit per cycle in SHIFT,
// and holds the result in DONE until the consumer takes it.
module alu_exec_stage
   import alu_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int SHW   = DEF_SHW
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_illegal,
   output logic             busy
);

   localparam logic [SHW-1:0] CNT_LAST = {{(SHW-1){1'b0}}, 1'b1};

   state_e           state_q, state_d;
   logic [WIDTH-1:0] data_q;
   logic [SHW-1:0]   cnt_q;
   logic             dir_right_q;
   logic             ill_q;

   logic             accept;
   logic             shift_start;
   logic [SHW-1:0]   amt;
   logic [WIDTH-1:0] comb_result;
   logic             comb_illegal;

   alu_comb #(.W(WIDTH)) u_alu_comb (
      .op_i      (in_op),
      .a_i       (in_a),
      .b_i       (in_b),
      .result_o  (comb_result),
      .illegal_o (comb_illegal)
   );

   assign amt         = in_b[SHW-1:0];
   assign accept      = in_valid && in_ready;
   assign shift_start = accept && is_shift(in_op) && (amt != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (accept) state_d = shift_start ? ST_SHIFT : ST_DONE;
         ST_SHIFT: if (cnt_q == CNT_LAST) state_d = ST_DONE;
         ST_DONE:  if (out_ready) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == ST_IDLE);
      busy      = (state_q == ST_SHIFT);
      out_valid = (state_q == ST_DONE);
   end

   // data_q doubles as the shift register; it only holds the final result in DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q      <= '0;
         cnt_q       <= '0;
         dir_right_q <= 1'b0;
         ill_q       <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  ill_q <= comb_illegal;
                  if (shift_start) begin
                     data_q      <= in_a;
                     cnt_q       <= amt;
                     dir_right_q <= (in_op == OP_SRL);
                  end else begin
                     data_q <= comb_result;
                  end
               end
            end
            ST_SHIFT: begin
               data_q <= dir_right_q ? (data_q >> 1) : (data_q << 1);
               cnt_q  <= cnt_q - 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign out_result  = data_q;
   assign out_illegal = ill_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Randomized and directed checks of alu_exec_stage against a behavioural model
// of the op set, handshake latency and shift timing.
module tb_alu_exec_stage;
   import alu_pkg::*;

   localparam int W = 33;  // {illegal, result}

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_op;
   logic [31:0] in_a;
   logic [31:0] in_b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic        out_illegal;
   logic        busy;

   int n_checks = 0;
   int n_errors = 0;
   logic [W-1:0] exp_q[$];
   int           lat_q[$];
   logic [W-1:0] last_exp;

   always #5 clk = ~clk;

   alu_exec_stage dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_op       (in_op),
      .in_a        (in_a),
      .in_b        (in_b),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_result  (out_result),
      .out_illegal (out_illegal),
      .busy        (busy)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
      int unsigned amt;
      amt = b % 32;
      case (op)
         4'd0:    return {1'b0, a + b};
         4'd1:    return {1'b0, a - b};
         4'd2:    return {1'b0, a & b};
         4'd3:    return {1'b0, a ^ b};
         4'd4:    return {1'b0, a | b};
         4'd5:    return {1'b0, a << amt};
         4'd6:    return {1'b0, a >> amt};
         4'd7:    return {1'b0, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0};
         4'd8:    return {1'b0, (a < b) ? 32'd1 : 32'd0};
         default: return {1'b1, 32'd0};
      endcase
   endfunction

   // Negedges from accept until out_valid is seen.
   function automatic int model_latency(input logic [3:0] op, input logic [31:0] b);
      int unsigned amt;
      amt = b % 32;
      if ((op == 4'd5 || op == 4'd6) && amt != 0) return int'(amt) + 1;
      return 1;
   endfunction

   task automatic reset_vals(input string tag);
      check({tag, "_in_ready"}, 64'(in_ready), 64'(1));
      check({tag, "_out_valid"}, 64'(out_valid), 64'(0));
      check({tag, "_out_result"}, 64'(out_result), 64'(0));
      check({tag, "_out_illegal"}, 64'(out_illegal), 64'(0));
      check({tag, "_busy"}, 64'(busy), 64'(0));
   endtask

   // Called just after a negedge; returns just after the accepting posedge.
   task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      int t;
      t = 0;
      in_valid = 1'b1;
      in_op    = op;
      in_a     = a;
      in_b     = b;
      exp_q.push_back(model(op, a, b));
      lat_q.push_back(model_latency(op, b));
      while (!in_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      check("accept_wait", 64'(t < 200), 64'(1));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_op    = 4'($urandom);
      in_a     = $urandom;
      in_b     = $urandom;
   endtask

   task automatic collect();
      int lat;
      int bsy;
      int el;
      lat = 0;
      bsy = 0;
      do begin
         @(negedge clk);
         lat++;
         if (busy) bsy++;
      end while (!out_valid && lat < 100);
      last_exp = exp_q.pop_front();
      el = lat_q.pop_front();
      check("latency", 64'(lat), 64'(el));
      check("busy_cycles", 64'(bsy), 64'(el - 1));
      check("result", 64'(out_result), 64'(last_exp[31:0]));
      check("illegal", 64'(out_illegal), 64'(last_exp[32]));
   endtask

   task automatic stall(input int n);
      repeat (n) begin
         @(negedge clk);
         check("hold_valid", 64'(out_valid), 64'(1));
         check("hold_result", 64'(out_result), 64'(last_exp[31:0]));
         check("hold_illegal", 64'(out_illegal), 64'(last_exp[32]));
         check("hold_in_ready", 64'(in_ready), 64'(0));
      end
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      check("post_hs_valid", 64'(out_valid), 64'(0));
      check("post_hs_in_ready", 64'(in_ready), 64'(1));
   endtask

   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int stall_n);
      send(op, a, b);
      collect();
      stall(stall_n);
      handshake();
   endtask

   initial begin
      logic saw_valid;
      logic [3:0]  r_op;
      logic [31:0] r_b;

      in_valid  = 1'b0;
      in_op     = '0;
      in_a      = '0;
      in_b      = '0;
      out_ready = 1'b0;

      // clock/reset
      repeat (3) @(negedge clk);
      reset_vals("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // directed ops
      run_op(OP_ADD,  32'hFFFF_FFFF, 32'd1, 0);
      run_op(OP_SLT,  32'hFFFF_FFFF, 32'd1, 0);
      run_op(OP_SLTU, 32'hFFFF_FFFF, 32'd1, 0);
      run_op(OP_SUB,  32'd0,         32'd1, 0);
      run_op(OP_SLL,  32'd1,         32'h0000_003F, 0);
      run_op(OP_SRL,  32'h8000_0000, 32'd0, 0);
      run_op(4'hF,    32'h1234_5678, 32'h9ABC_DEF0, 0);

      // backpressure with a competing request held upstream
      send(OP_XOR, 32'hA5A5_0F0F, 32'h0F0F_FFFF);
      collect();
      in_valid = 1'b1;
      in_op    = OP_ADD;
      in_a     = 32'd7;
      in_b     = 32'd9;
      stall(5);
      handshake();
      send(OP_ADD, 32'd7, 32'd9);
      collect();
      handshake();

      // reset in the middle of a shift
      send(OP_SLL, 32'd1, 32'd20);
      repeat (7) @(negedge clk);
      check("mid_shift_busy", 64'(busy), 64'(1));
      #2 rst_n = 1'b0;
      #1 reset_vals("rst_mid_shift");
      exp_q.delete();
      lat_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      saw_valid = 1'b0;
      repeat (30) begin
         @(negedge clk);
         if (out_valid) saw_valid = 1'b1;
      end
      check("no_result_after_reset", 64'(saw_valid), 64'(0));
      run_op(OP_ADD, 32'd2, 32'd3, 0);

      // randomized ops
      for (int i = 0; i < 40; i++) begin
         r_op = 4'($urandom_range(0, 15));
         r_b  = $urandom;
         if ($urandom_range(0, 3) == 0) r_b[4:0] = 5'd0;
         run_op(r_op, $urandom, r_b, $urandom_range(0, 3));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
